// File: rtl/spike_rate_encoder_if.sv
// Handshake bundle between the image source / network side and the spike rate encoder.
// The encoder connects through the slave modport; the image source and network use master.
interface spike_rate_encoder_if #(
    parameter int N_INPUTS   = 4,
    parameter int INT_W      = 8,
    parameter int STEP_CNT_W = 5
);
    logic                      img_valid;
    logic                      img_ready;
    logic [N_INPUTS*INT_W-1:0] img_data;
    logic                      sample;
    logic                      sample_ready;
    logic [N_INPUTS-1:0]       in_spikes;
    logic [STEP_CNT_W-1:0]     step_idx;
    logic                      busy;

    modport master (
        output img_valid, img_data, sample,
        input  img_ready, sample_ready, in_spikes, step_idx, busy
    );

    modport slave (
        input  img_valid, img_data, sample,
        output img_ready, sample_ready, in_spikes, step_idx, busy
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate coder: holds one image and presents N_STEPS spike vectors, one per
// network sample pulse, each drawn against a free-running 16-bit Galois LFSR.
module spike_rate_encoder #(
    parameter int          N_INPUTS   = 4,
    parameter int          INT_W      = 8,
    parameter int          N_STEPS    = 10,
    parameter int          STEP_CNT_W = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic clk,
    input logic rst,
    spike_rate_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENCODE, PRESENT} state_t;

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

    state_t                    state;
    logic [15:0]               lfsr;
    logic [15:0]               lfsr_next;
    logic [N_INPUTS*INT_W-1:0] intensity;
    logic [N_INPUTS-1:0]       spikes;
    logic                      present_vld;
    logic [STEP_CNT_W-1:0]     step_cnt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Channel i compares against a differently rotated view of the LFSR so the
    // channels do not all see the same random draw.
    function automatic logic [N_INPUTS-1:0] encode(input logic [15:0] l,
                                                    input logic [N_INPUTS*INT_W-1:0] img);
        logic [31:0]      dbl;
        logic [15:0]      rot;
        logic [INT_W-1:0] rnd;
        logic [INT_W-1:0] val;
        encode = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            dbl       = {l, l} << ((3 * i) % 16);
            rot       = dbl[31:16];
            rnd       = rot[INT_W-1:0];
            val       = img[i*INT_W +: INT_W];
            encode[i] = (val > rnd) || (&val);
        end
    endfunction

    assign lfsr_next = lfsr_step(lfsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            intensity   <= '0;
            spikes      <= '0;
            present_vld <= 1'b0;
            step_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.img_valid) begin
                        intensity <= bus.img_data;
                        state     <= ENCODE;
                    end
                end
                ENCODE: begin
                    lfsr        <= lfsr_next;
                    spikes      <= encode(lfsr_next, intensity);
                    step_cnt    <= '0;
                    present_vld <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (bus.sample) begin
                        if (step_cnt == LAST_STEP) begin
                            present_vld <= 1'b0;
                            spikes      <= '0;
                            step_cnt    <= '0;
                            state       <= IDLE;
                        end else begin
                            // Next vector is ready on the same edge, so no bubble.
                            lfsr     <= lfsr_next;
                            spikes   <= encode(lfsr_next, intensity);
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.img_ready    = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.sample_ready = present_vld;
    assign bus.in_spikes    = spikes;
    assign bus.step_idx     = step_cnt;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: table of images with hand-computed first two
// spike vectors after reset, plus sequences for timing, stalls and mid-image reset.
module tb_spike_rate_encoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    spike_rate_encoder_if #(.N_INPUTS(4), .INT_W(8), .STEP_CNT_W(5)) bus ();

    spike_rate_encoder #(
        .N_INPUTS(4), .INT_W(8), .N_STEPS(10), .STEP_CNT_W(5), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] img;
        logic [3:0]  s0;
        logic [3:0]  s1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.img_valid = 1'b0;
        bus.sample    = 1'b0;
        bus.img_data  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Handshake in the current IDLE cycle, then follow ENCODE into PRESENT.
    task automatic load_image(input logic [31:0] data);
        chk("load_img_ready", {31'd0, bus.img_ready}, 32'd1);
        bus.img_valid = 1'b1;
        bus.img_data  = data;
        tick();
        bus.img_valid = 1'b0;
        chk("encode_busy", {31'd0, bus.busy}, 32'd1);
        chk("encode_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        tick();
        chk("present_sample_ready", {31'd0, bus.sample_ready}, 32'd1);
    endtask

    task automatic pulse_sample();
        bus.sample = 1'b1;
        tick();
        bus.sample = 1'b0;
    endtask

    logic [3:0] seq_exp[5];
    int cnt;

    initial begin
        bus.img_valid = 1'b0;
        bus.sample    = 1'b0;
        bus.img_data  = '0;

        // LFSR after ENCODE = 0xE270 -> rnd {ch3..ch0} = C4,38,87,70
        // after first sample = 0x7138 -> rnd = E2,1C,C3,38
        vecs[0] = '{img: 32'h0000_0070, s0: 4'h0, s1: 4'h1};
        vecs[1] = '{img: 32'h0000_0071, s0: 4'h1, s1: 4'h1};
        vecs[2] = '{img: 32'hC539_8770, s0: 4'hC, s1: 4'h5};
        vecs[3] = '{img: 32'hC438_8871, s0: 4'h3, s1: 4'h5};
        vecs[4] = '{img: 32'hFF00_FF00, s0: 4'hA, s1: 4'hA};
        vecs[5] = '{img: 32'h8080_8080, s0: 4'h5, s1: 4'h5};

        // Reset state
        do_reset();
        chk("rst_img_ready", {31'd0, bus.img_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("rst_in_spikes", {28'd0, bus.in_spikes}, 32'd0);
        chk("rst_step_idx", {27'd0, bus.step_idx}, 32'd0);

        // All-zero image, sample pulses spaced 3 cycles
        load_image(32'h0000_0000);
        for (int k = 0; k < 10; k++) begin
            chk("zero_spikes", {28'd0, bus.in_spikes}, 32'd0);
            chk("zero_step_idx", {27'd0, bus.step_idx}, k);
            pulse_sample();
            if (k < 9) begin
                tick();
                tick();
                chk("zero_hold_step_idx", {27'd0, bus.step_idx}, k + 1);
            end
        end
        chk("zero_end_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("zero_end_img_ready", {31'd0, bus.img_ready}, 32'd1);
        chk("zero_end_step_idx", {27'd0, bus.step_idx}, 32'd0);

        // All-ones image, sample held high
        load_image(32'hFFFF_FFFF);
        bus.sample = 1'b1;
        cnt = 0;
        while (bus.sample_ready && cnt < 30) begin
            chk("ones_spikes", {28'd0, bus.in_spikes}, 32'hF);
            cnt++;
            tick();
        end
        bus.sample = 1'b0;
        chk("ones_step_count", cnt, 32'd10);
        chk("ones_end_in_spikes", {28'd0, bus.in_spikes}, 32'd0);

        // Table: each image from reset, first two vectors
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load_image(vecs[v].img);
            chk($sformatf("tbl%0d_s0", v), {28'd0, bus.in_spikes}, {28'd0, vecs[v].s0});
            chk($sformatf("tbl%0d_idx0", v), {27'd0, bus.step_idx}, 32'd0);
            pulse_sample();
            chk($sformatf("tbl%0d_s1", v), {28'd0, bus.in_spikes}, {28'd0, vecs[v].s1});
            chk($sformatf("tbl%0d_idx1", v), {27'd0, bus.step_idx}, 32'd1);
        end

        // Sample pulses in IDLE and during ENCODE are ignored
        do_reset();
        bus.sample = 1'b1;
        tick();
        chk("idle_sample_img_ready", {31'd0, bus.img_ready}, 32'd1);
        chk("idle_sample_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        bus.img_valid = 1'b1;
        bus.img_data  = 32'h0000_0070;
        tick();
        bus.img_valid = 1'b0;
        chk("encode_with_sample_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        bus.sample = 1'b0;
        chk("ign_sample_ready", {31'd0, bus.sample_ready}, 32'd1);
        chk("ign_s0", {28'd0, bus.in_spikes}, 32'h0);
        chk("ign_idx0", {27'd0, bus.step_idx}, 32'd0);
        // rnd0 for steps 1..5: 38, 9C, 4E, 27, 13 against intensity 0x70
        seq_exp[0] = 4'h1; seq_exp[1] = 4'h0; seq_exp[2] = 4'h1;
        seq_exp[3] = 4'h1; seq_exp[4] = 4'h1;
        for (int s = 0; s < 5; s++) begin
            pulse_sample();
            chk($sformatf("seq_step%0d", s + 1), {28'd0, bus.in_spikes}, {28'd0, seq_exp[s]});
            chk($sformatf("seq_idx%0d", s + 1), {27'd0, bus.step_idx}, s + 1);
        end

        // Reset at step 5 discards the image and reseeds the LFSR
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        chk("midrst_in_spikes", {28'd0, bus.in_spikes}, 32'd0);
        chk("midrst_step_idx", {27'd0, bus.step_idx}, 32'd0);
        chk("midrst_img_ready", {31'd0, bus.img_ready}, 32'd1);
        load_image(32'hC438_8871);
        chk("midrst_reseed_s0", {28'd0, bus.in_spikes}, 32'h3);

        // New image offered during PRESENT waits for IDLE
        do_reset();
        load_image(32'h0000_0000);
        bus.img_valid = 1'b1;
        bus.img_data  = 32'hFFFF_FFFF;
        tick();
        chk("stall_img_ready", {31'd0, bus.img_ready}, 32'd0);
        chk("stall_spikes", {28'd0, bus.in_spikes}, 32'h0);
        bus.sample = 1'b1;
        cnt = 0;
        while (bus.sample_ready && cnt < 30) begin
            cnt++;
            tick();
        end
        bus.sample = 1'b0;
        chk("stall_step_count", cnt, 32'd10);
        chk("stall_idle_img_ready", {31'd0, bus.img_ready}, 32'd1);
        tick();
        bus.img_valid = 1'b0;
        chk("stall_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("stall_accept_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        tick();
        chk("stall_new_sample_ready", {31'd0, bus.sample_ready}, 32'd1);
        chk("stall_new_spikes", {28'd0, bus.in_spikes}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
